// File: rtl/ssp_tx_fifo_gen.sv
// Transmit FIFO with registered read port, occupancy count, sticky error flags.
// Optional watermark interrupt enabled by defining SSP_TXFIFO_WMARK_EN.
module ssp_tx_fifo_gen #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  PCLK,
    input  logic                  CLEAR,
    input  logic                  PSEL,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  READ_CMD,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    output logic                  SSPTXINTR,
    output logic                  START_SIGNAL,
    output logic [ADDR_WIDTH:0]   LEVEL,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
    input  logic                  ERR_CLR,
    input  logic [ADDR_WIDTH:0]   WMARK,
    output logic                  SSPTXWMINTR
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned LW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  full_q, full_d;
    logic                  nempty_q, nempty_d;
    logic                  full, empty, wr_acc, rd_acc;

    // Accept decisions come only from registered occupancy.
    always_comb begin
        full       = (level_q == LW'(DEPTH));
        empty      = (level_q == '0);
        rd_acc     = READ_CMD & ~empty;
        wr_acc     = PSEL & PWRITE & (~full | rd_acc);
        wr_ptr_d   = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d   = rd_acc ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        tx_data_d  = rd_acc ? mem_q[rd_ptr_q] : tx_data_q;
        tx_valid_d = rd_acc;
        level_d    = level_q;
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // A fresh error outranks a same-cycle clear.
        ovf_d    = (PSEL & PWRITE & ~wr_acc) | (ovf_q & ~ERR_CLR);
        udf_d    = (READ_CMD & empty) | (udf_q & ~ERR_CLR);
        full_d   = (level_d == LW'(DEPTH));
        nempty_d = (level_d != '0);
    end

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            full_q     <= 1'b0;
            nempty_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            full_q     <= full_d;
            nempty_q   <= nempty_d;
        end
    end

    // Storage is not reset; cleared pointers make stale entries unreachable.
    always_ff @(posedge PCLK) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= PWDATA;
        end
    end

    assign TX_DATA      = tx_data_q;
    assign TX_VALID     = tx_valid_q;
    assign SSPTXINTR    = full_q;
    assign START_SIGNAL = nempty_q;
    assign LEVEL        = level_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = udf_q;

`ifdef SSP_TXFIFO_WMARK_EN
    logic wm_q;

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            wm_q <= 1'b0;
        end else begin
            wm_q <= (level_d <= WMARK);
        end
    end

    assign SSPTXWMINTR = wm_q;
`else
    logic unused_wmark;
    assign unused_wmark = ^WMARK;
    assign SSPTXWMINTR  = 1'b0;
`endif

endmodule

// File: tb/tb_ssp_tx_fifo_gen.sv
// Randomized self-checking bench for ssp_tx_fifo_gen against a queue-based reference model.
module tb_ssp_tx_fifo_gen;

    logic       PCLK = 1'b0;
    logic       CLEAR = 1'b0;
    logic       PSEL = 1'b0;
    logic       PWRITE = 1'b0;
    logic [7:0] PWDATA = '0;
    logic       READ_CMD = 1'b0;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       SSPTXINTR;
    logic       START_SIGNAL;
    logic [3:0] LEVEL;
    logic       OVERFLOW;
    logic       UNDERFLOW;
    logic       ERR_CLR = 1'b0;
    logic [3:0] WMARK = 4'd2;
    logic       SSPTXWMINTR;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq[$];
    logic [7:0] m_tx = '0;
    bit         m_valid = 0, m_ovf = 0, m_udf = 0, m_wm = 0;

    ssp_tx_fifo_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .PCLK(PCLK), .CLEAR(CLEAR), .PSEL(PSEL), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .READ_CMD(READ_CMD), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .SSPTXINTR(SSPTXINTR), .START_SIGNAL(START_SIGNAL), .LEVEL(LEVEL),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .ERR_CLR(ERR_CLR),
        .WMARK(WMARK), .SSPTXWMINTR(SSPTXWMINTR)
    );

    always #5 PCLK = ~PCLK;

    // Apply one cycle of stimulus, then advance the reference model.
    task automatic drive(input bit psel, input bit pwrite, input logic [7:0] wd,
                         input bit rd, input bit clr_err);
        bit full_b, empty_b, rok, wok;
        PSEL = psel; PWRITE = pwrite; PWDATA = wd; READ_CMD = rd; ERR_CLR = clr_err;
        full_b  = (mq.size() == 8);
        empty_b = (mq.size() == 0);
        rok = rd && !empty_b;
        wok = psel && pwrite && (!full_b || rok);
        @(posedge PCLK); #1;
        m_valid = rok;
        if (rok) m_tx = mq.pop_front();
        if (wok) mq.push_back(wd);
        m_ovf = (psel && pwrite && !wok) || (m_ovf && !clr_err);
        m_udf = (rd && empty_b) || (m_udf && !clr_err);
`ifdef SSP_TXFIFO_WMARK_EN
        m_wm = (mq.size() <= int'(WMARK));
`else
        m_wm = 0;
`endif
        PSEL = 0; PWRITE = 0; READ_CMD = 0; ERR_CLR = 0;
    endtask

    task automatic model_clear();
        mq.delete();
        m_tx = '0; m_valid = 0; m_ovf = 0; m_udf = 0; m_wm = 0;
    endtask

    task automatic test_reset();
        CLEAR = 1'b0; #1 CLEAR = 1'b1; #2;
        model_clear();
        n_checks++;
        if ({LEVEL, TX_DATA, TX_VALID, OVERFLOW, UNDERFLOW, SSPTXINTR, START_SIGNAL, SSPTXWMINTR} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_async: got level=%0d tx=%h flags=%b%b%b%b%b%b required all zero",
                     LEVEL, TX_DATA, TX_VALID, OVERFLOW, UNDERFLOW, SSPTXINTR, START_SIGNAL, SSPTXWMINTR);
        end
        @(posedge PCLK); #1;
        CLEAR = 1'b0;
        n_checks++;
        if (LEVEL !== 4'd0 || START_SIGNAL !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: got level=%0d start=%b required 0/0", LEVEL, START_SIGNAL);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        for (int i = 0; i < 3; i++) drive(1, 1, exp_d[i], 0, 0);
        n_checks++;
        if (LEVEL !== 4'd3 || START_SIGNAL !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_fill: got level=%0d start=%b required 3/1", LEVEL, START_SIGNAL);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 8'h00, 1, 0);
            n_checks++;
            if (TX_DATA !== exp_d[i] || TX_VALID !== 1'b1 || LEVEL !== 4'(2 - i)) begin
                n_fail++;
                $display("FAIL basic_read%0d: got tx=%h v=%b level=%0d required %h/1/%0d",
                         i, TX_DATA, TX_VALID, LEVEL, exp_d[i], 2 - i);
            end
        end
        n_checks++;
        if (START_SIGNAL !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_start_fall: got %b required 0", START_SIGNAL);
        end
        drive(0, 0, 8'h00, 0, 0);
        n_checks++;
        if (TX_VALID !== 1'b0 || TX_DATA !== 8'h33) begin
            n_fail++;
            $display("FAIL basic_hold: got tx=%h v=%b required 33/0", TX_DATA, TX_VALID);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) drive(1, 1, 8'($urandom_range(0, 254)), 0, 0);
        n_checks++;
        if (SSPTXINTR !== 1'b1 || LEVEL !== 4'd8) begin
            n_fail++;
            $display("FAIL ovf_full: got intr=%b level=%0d required 1/8", SSPTXINTR, LEVEL);
        end
        drive(1, 1, 8'hFF, 0, 0);
        n_checks++;
        if (OVERFLOW !== 1'b1 || LEVEL !== 4'd8) begin
            n_fail++;
            $display("FAIL ovf_set: got ovf=%b level=%0d required 1/8", OVERFLOW, LEVEL);
        end
        drive(0, 0, 8'h00, 0, 1);
        n_checks++;
        if (OVERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: got %b required 0", OVERFLOW);
        end
    endtask

    task automatic test_full_simul();
        drive(1, 1, 8'hA5, 1, 0);
        n_checks++;
        if (LEVEL !== 4'd8 || OVERFLOW !== 1'b0 || TX_DATA !== m_tx || TX_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL full_simul: got level=%0d ovf=%b tx=%h required 8/0/%h",
                     LEVEL, OVERFLOW, TX_DATA, m_tx);
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 8'h00, 1, 0);
            n_checks++;
            if (TX_DATA !== m_tx || TX_DATA === 8'hFF) begin
                n_fail++;
                $display("FAIL full_drain%0d: got %h required %h", i, TX_DATA, m_tx);
            end
        end
        n_checks++;
        if (TX_DATA !== 8'hA5 || LEVEL !== 4'd0) begin
            n_fail++;
            $display("FAIL full_last: got tx=%h level=%0d required a5/0", TX_DATA, LEVEL);
        end
    endtask

    task automatic test_empty_simul();
        drive(1, 1, 8'h5A, 1, 0);
        n_checks++;
        if (UNDERFLOW !== 1'b1 || LEVEL !== 4'd1 || TX_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_simul: got udf=%b level=%0d v=%b required 1/1/0",
                     UNDERFLOW, LEVEL, TX_VALID);
        end
        drive(0, 0, 8'h00, 1, 0);
        n_checks++;
        if (TX_DATA !== 8'h5A || TX_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_next_read: got %h/%b required 5a/1", TX_DATA, TX_VALID);
        end
        // Error arriving together with clear must leave the flag set.
        drive(0, 0, 8'h00, 1, 1);
        n_checks++;
        if (UNDERFLOW !== 1'b1 || TX_DATA !== 8'h5A || TX_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL udf_set_wins: got udf=%b tx=%h v=%b required 1/5a/0",
                     UNDERFLOW, TX_DATA, TX_VALID);
        end
        drive(0, 0, 8'h00, 0, 1);
        n_checks++;
        if (UNDERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL udf_clr: got %b required 0", UNDERFLOW);
        end
    endtask

    task automatic test_no_psel();
        drive(0, 1, 8'h77, 0, 0);
        n_checks++;
        if (LEVEL !== 4'(mq.size()) || OVERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL no_psel: got level=%0d ovf=%b required %0d/0", LEVEL, OVERFLOW, mq.size());
        end
    endtask

    task automatic test_wrap();
        logic [7:0] in_s[$];
        logic [7:0] out_s[$];
        logic [7:0] d;
        while (mq.size() < 4) drive(1, 1, 8'($urandom), 0, 0);
        for (int i = 0; i < 4; i++) in_s.push_back(mq[i]);
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            in_s.push_back(d);
            drive(1, 1, d, 1, 0);
            out_s.push_back(TX_DATA);
            n_checks++;
            if (LEVEL !== 4'd4 || TX_VALID !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_level%0d: got %0d/%b required 4/1", i, LEVEL, TX_VALID);
            end
        end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (out_s[i] !== in_s[i]) begin
                n_fail++;
                $display("FAIL wrap_order%0d: got %h required %h", i, out_s[i], in_s[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 4) != 0, 8'($urandom),
                  ($urandom % 2) == 1, ($urandom % 8) == 0);
            n_checks++;
            if (LEVEL !== 4'(mq.size()) || TX_VALID !== m_valid || TX_DATA !== m_tx ||
                OVERFLOW !== m_ovf || UNDERFLOW !== m_udf || SSPTXWMINTR !== m_wm ||
                SSPTXINTR !== (mq.size() == 8) || START_SIGNAL !== (mq.size() != 0)) begin
                n_fail++;
                $display("FAIL random%0d: got lvl=%0d v=%b tx=%h o=%b u=%b wm=%b f=%b s=%b required lvl=%0d v=%b tx=%h o=%b u=%b wm=%b",
                         i, LEVEL, TX_VALID, TX_DATA, OVERFLOW, UNDERFLOW, SSPTXWMINTR,
                         SSPTXINTR, START_SIGNAL, mq.size(), m_valid, m_tx, m_ovf, m_udf, m_wm);
            end
        end
    endtask

    task automatic test_watermark();
        WMARK = 4'd2;
        while (mq.size() > 0) drive(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 8'(i + 1), 0, 0);
        n_checks++;
`ifdef SSP_TXFIFO_WMARK_EN
        if (LEVEL !== 4'd3 || SSPTXWMINTR !== 1'b0) begin
`else
        if (LEVEL !== 4'd3 || SSPTXWMINTR !== m_wm) begin
`endif
            n_fail++;
            $display("FAIL wmark_above: got level=%0d wm=%b required 3/0", LEVEL, SSPTXWMINTR);
        end
        drive(0, 0, 8'h00, 1, 0);
        n_checks++;
        if (LEVEL !== 4'd2 || SSPTXWMINTR !== m_wm) begin
            n_fail++;
            $display("FAIL wmark_at: got level=%0d wm=%b required 2/%b", LEVEL, SSPTXWMINTR, m_wm);
        end
        WMARK = 4'd8;
        for (int i = 0; i < 6; i++) drive(1, 1, 8'(i), 0, 0);
        n_checks++;
        if (LEVEL !== 4'd8 || SSPTXWMINTR !== m_wm) begin
            n_fail++;
            $display("FAIL wmark_depth: got level=%0d wm=%b required 8/%b", LEVEL, SSPTXWMINTR, m_wm);
        end
        WMARK = 4'd2;
    endtask

    task automatic test_clear_mid();
        while (mq.size() < 3) drive(1, 1, 8'($urandom), 0, 0);
        drive(1, 1, 8'h00, 1, 0);
        PSEL = 1; PWRITE = 1; PWDATA = 8'hEE; READ_CMD = 1;
        #2 CLEAR = 1'b1;
        #1;
        model_clear();
        n_checks++;
        if ({LEVEL, TX_DATA, TX_VALID, OVERFLOW, UNDERFLOW, SSPTXINTR, START_SIGNAL, SSPTXWMINTR} !== 18'd0) begin
            n_fail++;
            $display("FAIL clear_mid_async: got level=%0d tx=%h flags=%b%b%b%b%b%b required all zero",
                     LEVEL, TX_DATA, TX_VALID, OVERFLOW, UNDERFLOW, SSPTXINTR, START_SIGNAL, SSPTXWMINTR);
        end
        @(posedge PCLK); #1;
        n_checks++;
        if (LEVEL !== 4'd0 || TX_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_abort: got level=%0d v=%b required 0/0", LEVEL, TX_VALID);
        end
        PSEL = 0; PWRITE = 0; READ_CMD = 0;
        CLEAR = 1'b0;
        drive(1, 1, 8'h3C, 0, 0);
        n_checks++;
        if (LEVEL !== 4'd1) begin
            n_fail++;
            $display("FAIL clear_first_write: got level=%0d required 1", LEVEL);
        end
        drive(0, 0, 8'h00, 1, 0);
        n_checks++;
        if (TX_DATA !== 8'h3C || LEVEL !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_stale: got tx=%h level=%0d required 3c/0", TX_DATA, LEVEL);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_simul();
        test_empty_simul();
        test_no_psel();
        test_wrap();
        test_random();
        test_watermark();
        test_clear_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ssp_tx_fifo_gen.md
SSP_TX_FIFO_GEN -- requirements
Module: ssp_tx_fifo_gen

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, bits per entry.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, pointer width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 The block SHALL have one clock and asynchronous active-high reset: PCLK in 1, sole clock, all state on rising edge; CLEAR in 1, async active-high reset.
REQ-004 The block SHALL have these ports:
- PSEL  in  1  bus select, qualifies writes.
- PWRITE  in  1  write request.
- PWDATA  in  DATA_WIDTH  write data.
- READ_CMD  in  1  read request from transmit logic.
- TX_DATA  out  DATA_WIDTH  registered read data.
- TX_VALID  out  1  TX_DATA updated this cycle.
- SSPTXINTR  out  1  FIFO full.
- START_SIGNAL  out  1  FIFO not empty.
- LEVEL  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- OVERFLOW  out  1  sticky, write attempted while full.
- UNDERFLOW  out  1  sticky, read attempted while empty.
- ERR_CLR  in  1  clears OVERFLOW and UNDERFLOW.
- WMARK  in  ADDR_WIDTH+1  watermark threshold (used only with SSP_TXFIFO_WMARK_EN).
- SSPTXWMINTR  out  1  level at or below watermark (0 without SSP_TXFIFO_WMARK_EN).

Function
REQ-005 Write accept: wr_acc = PSEL & PWRITE & (~full | rd_acc); on wr_acc, mem[wr_ptr] <= PWDATA and wr_ptr increments modulo DEPTH.
REQ-006 Read accept: rd_acc = READ_CMD & ~empty; on rd_acc, TX_DATA <= mem[rd_ptr], TX_VALID = 1 for the following cycle, rd_ptr increments modulo DEPTH.
REQ-007 Read latency SHALL be one cycle: data appears on TX_DATA at the edge that accepts the read; TX_DATA holds its value while no read is accepted.
REQ-008 LEVEL SHALL be registered: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-009 full = (LEVEL == DEPTH); empty = (LEVEL == 0); SSPTXINTR = full; START_SIGNAL = ~empty; all derived from registered state only.
REQ-010 Full with simultaneous write and read: both accepted, LEVEL stays DEPTH, no overflow.
REQ-011 Empty with simultaneous write and read: write accepted, read rejected (no fall-through), UNDERFLOW set, LEVEL becomes 1.
REQ-012 PSEL & PWRITE while full and no rd_acc: data dropped, pointers unchanged, OVERFLOW set next edge.
REQ-013 READ_CMD while empty and no write: pointers unchanged, TX_DATA held, TX_VALID 0, UNDERFLOW set.
REQ-014 OVERFLOW/UNDERFLOW SHALL remain set until ERR_CLR; if ERR_CLR coincides with a new error event, the flag stays set (set wins).
REQ-015 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; no entry lost or duplicated across wrap.
REQ-016 PWRITE without PSEL SHALL have no effect and no error.

Reset
REQ-017 CLEAR high SHALL immediately, independent of PCLK, force: pointers 0, LEVEL 0, TX_DATA 0, TX_VALID 0, OVERFLOW 0, UNDERFLOW 0, SSPTXINTR 0, START_SIGNAL 0, SSPTXWMINTR 0 with SSP_TXFIFO_WMARK_EN.
REQ-018 Memory contents SHALL not be reset; data queued before CLEAR is discarded (not readable).
REQ-019 CLEAR asserted mid-transfer SHALL abort any accept in that cycle; first accept after release occurs on the first PCLK edge with CLEAR low.

Configuration
REQ-020 Macro SSP_TXFIFO_WMARK_EN defined: SSPTXWMINTR registered, = (LEVEL <= WMARK) updated every edge from next LEVEL; WMARK sampled each cycle, WMARK >= DEPTH keeps SSPTXWMINTR high.
REQ-021 Macro SSP_TXFIFO_WMARK_EN undefined: no watermark logic; SSPTXWMINTR tied 0; WMARK ignored.

Verification
REQ-022 Reset, write 0x11,0x22,0x33 (DEPTH=8), then READ_CMD x3 -> TX_DATA 0x11,0x22,0x33 each one cycle after accept, LEVEL 3->0, START_SIGNAL falls with last read.
REQ-023 Write 8 entries -> SSPTXINTR=1, LEVEL=8; 9th write 0xFF -> OVERFLOW=1, 0xFF never read; ERR_CLR -> OVERFLOW=0.
REQ-024 Full FIFO, simultaneous write 0xA5 and read -> LEVEL stays 8, no OVERFLOW; eight further reads end with 0xA5.
REQ-025 Empty FIFO, simultaneous write 0x5A and read -> UNDERFLOW=1, LEVEL=1, next read returns 0x5A.
REQ-026 20 write/read cycles at LEVEL 4 across wrap -> output stream equals input stream in order.
REQ-027 With SSP_TXFIFO_WMARK_EN, WMARK=2: LEVEL 3 -> SSPTXWMINTR 0, read to LEVEL 2 -> 1; CLEAR asserted mid-burst -> LEVEL 0, all flags 0 asynchronously.
